// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, with a
// carry-lookahead trial subtractor. Optional early exit on zero divisor: DIV_ZERO_CHK_EN.
module seq_restoring_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned AW = VW + 1;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dsr;
  logic [VW-1:0] dvs;
  logic [VW-1:0] r;
  logic [CW-1:0] count;

  logic [AW-1:0] t;
  logic [AW-1:0] y_n;
  logic [AW-1:0] g;
  logic [AW-1:0] p;
  logic [VW:0]   c;
  logic          acc;
  logic          pp;
  logic          cout;
  logic [VW-1:0] diff;
  logic          qbit;
  logic [VW-1:0] r_next;
  logic [DW-1:0] dsr_next;

  // Trial subtraction T + ~{0,divisor} + 1; each carry is formed from the
  // generate/propagate terms directly rather than rippled from the previous carry.
  always_comb begin
    t      = {r, dsr[DW-1]};
    y_n    = ~{1'b0, dvs};
    g      = t & y_n;
    p      = t ^ y_n;
    c      = '0;
    acc    = 1'b0;
    pp     = 1'b0;
    c[0]   = 1'b1;
    for (int i = 0; i < int'(VW); i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | pp;
    end
    cout     = g[VW] | (p[VW] & c[VW]);
    diff     = p[VW-1:0] ^ c[VW-1:0];
    qbit     = cout;
    r_next   = cout ? diff : t[VW-1:0];
    dsr_next = {dsr[DW-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dsr         <= '0;
      dvs         <= '0;
      r           <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dsr         <= dividend;
            dvs         <= divisor;
            r           <= '0;
            count       <= CW'(DW);
            div_by_zero <= 1'b0;
            state       <= RUN;
            busy        <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
            // Zero divisor skips the iterations and reports the flag right away.
            if (divisor == '0) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              count       <= '0;
              quotient    <= '1;
              remainder   <= dividend[VW-1:0];
              div_by_zero <= 1'b1;
            end
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dsr   <= dsr_next;
          r     <= r_next;
          count <= count - CW'(1);
          // Last iteration: publish results directly from the next-state values.
          if (count == CW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= dsr_next;
            remainder <= r_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: cycle-level arithmetic model plus
// directed corners and a randomized exhaustive operand sweep.
module tb_seq_restoring_divider;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
`ifdef DIV_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from plain / and %, timing as "done N edges after accept".
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [DW-1:0] m_q = '0;
  logic [VW-1:0] m_r = '0;
  logic          m_dz = 1'b0;
  int            m_left = 0;
  logic [DW-1:0] p_q = '0;
  logic [VW-1:0] p_r = '0;
  logic          p_dz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_dz <= 1'b0;
        if (divisor == 0) begin
          p_q <= '1; p_r <= dividend[VW-1:0]; p_dz <= ZCHK;
        end else begin
          p_q <= dividend / divisor; p_r <= VW'(dividend % divisor); p_dz <= 1'b0;
        end
        if (ZCHK && divisor == 0) begin
          m_done <= 1'b1; m_q <= '1; m_r <= dividend[VW-1:0]; m_dz <= 1'b1;
        end else begin
          m_busy <= 1'b1; m_left <= DW;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("quotient", int'(quotient), int'(m_q));
    chk("remainder", int'(remainder), int'(m_r));
    chk("div_by_zero", int'(div_by_zero), int'(m_dz));
  end

  // Waits (bounded) for done after an accept edge; lat = -1 on timeout.
  task automatic wait_done(output int lat, output int bcyc);
    lat = -1;
    bcyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int gap,
                       output int lat, output int bcyc);
    @(posedge clk);
    repeat (gap) @(posedge clk);
    #2 start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #2 start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
    wait_done(lat, bcyc);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int lat, bc, seen, off;
  logic [11:0] pair;
  logic [DW-1:0] ca [4] = '{8'd255, 8'd13, 8'd0, 8'd255};
  logic [VW-1:0] cb [4] = '{4'd15, 4'd14, 4'd5, 4'd1};
  int cq [4] = '{17, 0, 0, 255};
  int cr [4] = '{0, 13, 0, 0};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    do_op(8'd200, 4'd7, 0, lat, bc);
    chk("t1_latency", lat, 9);
    chk("t1_busy_cycles", bc, 8);
    chk("t1_quotient", int'(quotient), 28);
    chk("t1_remainder", int'(remainder), 4);
    chk("t1_model_q", int'(m_q), 28);
    chk("t1_model_r", int'(m_r), 4);

    for (int i = 0; i < 4; i++) begin
      do_op(ca[i], cb[i], 1, lat, bc);
      chk("corner_latency", lat, 9);
      chk("corner_quotient", int'(quotient), cq[i]);
      chk("corner_remainder", int'(remainder), cr[i]);
    end

    // Ignored start during RUN, then back-to-back accept from DONE.
    @(posedge clk);
    #2 start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk);
    #2 start = 1'b0; dividend = 8'd50; divisor = 4'd9;
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    chk("t3_done_seen", int'(done), 1);
    chk("t3_quotient", int'(quotient), 33);
    chk("t3_remainder", int'(remainder), 1);
    start = 1'b1; dividend = 8'd77; divisor = 4'd6;
    @(posedge clk);
    #2 start = 1'b0;
    #1 chk("t3_hold_quotient", int'(quotient), 33);
    chk("t3_done_dropped", int'(done), 0);
    wait_done(lat, bc);
    chk("t3_b2b_latency", lat, 9);
    chk("t3_b2b_quotient", int'(quotient), 12);
    chk("t3_b2b_remainder", int'(remainder), 5);

    do_op(8'd60, 4'd0, 0, lat, bc);
    chk("t4_latency", lat, ZCHK ? 1 : 9);
    chk("t4_quotient", int'(quotient), 255);
    chk("t4_remainder", int'(remainder), 12);
    chk("t4_flag", int'(div_by_zero), int'(ZCHK));

    // Asynchronous reset in the middle of a run.
    @(posedge clk);
    #2 start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_quotient", int'(quotient), 0);
    chk("t5_remainder", int'(remainder), 0);
    chk("t5_flag", int'(div_by_zero), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("t5_no_done", seen, 0);
    do_op(8'd9, 4'd2, 0, lat, bc);
    chk("t5_quotient_after", int'(quotient), 4);
    chk("t5_remainder_after", int'(remainder), 1);

    // Every operand pair, visited in a random permutation with random gaps.
    off = int'($urandom_range(0, 4095));
    for (int idx = 0; idx < 4096; idx++) begin
      pair = 12'((idx * 2897 + off) % 4096);
      do_op(pair[11:4], pair[3:0], int'($urandom_range(0, 1)), lat, bc);
      chk("sweep_latency", lat, (ZCHK && pair[3:0] == 0) ? 1 : 9);
      if (pair[3:0] != 0) begin
        chk("sweep_invariant", int'(quotient) * int'(pair[3:0]) + int'(remainder),
            int'(pair[11:4]));
        chk("sweep_rem_lt_div", int'(remainder < pair[3:0]), 1);
      end else begin
        chk("sweep_zero_q", int'(quotient), 255);
        chk("sweep_zero_r", int'(remainder), int'(pair[7:4]));
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
